fpnew_result_fifo: RTL

// - Elastic result buffer directly downstream of an opgroup block's output arbiter.
// - Stores {result, status, ext_bit, tag} tuples in a circular FIFO and decouples unit latency

---
 rtl/fpnew_pkg.sv | 16 +
 rtl/fpnew_result_fifo.sv | 114 +++++++++++
 2 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPnew types: exception status flags and their accumulation helper.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    function automatic status_t status_or(input status_t a, input status_t b);
        return status_t'(a | b);
    endfunction

endpackage

// File: rtl/fpnew_result_fifo.sv
// Elastic result buffer behind an opgroup output arbiter; also accumulates the
// sticky exception flags of every retired result.
module fpnew_result_fifo
    import fpnew_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] result_i,
    input  status_t          status_i,
    input  logic             extension_bit_i,
    input  TagType           tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] result_o,
    output status_t          status_o,
    output logic             extension_bit_o,
    output TagType           tag_o,
    output status_t          fflags_o,
    input  logic             clear_fflags_i,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic             busy_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext_bit;
        TagType           tag;
    } entry_t;

    entry_t            mem [Depth];
    logic [PtrW-1:0]   wr_ptr, rd_ptr;
    logic [CntW-1:0]   count;
    status_t           fflags;
    entry_t            head;

    logic full, empty, push, pop, pop_eff;
    status_t popped;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign push    = in_valid_i & in_ready_o;
    assign pop     = out_valid_o & out_ready_i;
    // A pop coinciding with flush is discarded, so it does not retire flags either.
    assign pop_eff = pop & ~flush_i;
    assign popped  = pop_eff ? status_o : '0;

    assign head            = mem[rd_ptr];
    assign in_ready_o      = ~full;
    assign out_valid_o     = ~empty;
    assign busy_o          = ~empty;
    assign count_o         = count;
    assign fflags_o        = fflags;
    assign result_o        = head.result;
    assign status_o        = head.status;
    assign extension_bit_o = head.ext_bit;
    assign tag_o           = head.tag;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Only entry 0 is reset so the head reads zero straight out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem[0] <= '0;
        end else if (push && !flush_i) begin
            mem[wr_ptr] <= '{result: result_i, status: status_i,
                             ext_bit: extension_bit_i, tag: tag_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)               fflags <= '0;
        else if (clear_fflags_i) fflags <= popped;
        else                     fflags <= status_or(fflags, popped);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && full));
            assert (32'(count) <= Depth);
            assert (out_valid_o == (count != '0));
        end
    end

endmodule
